// File: rtl/modport_bridge_if.sv
// AHB-Lite slave side plus APB v2 master side of the bridge, bundled as one bus.
// The slave modport is the bridge's view; the master modport is the fabric/peripheral view.
interface modport_bridge_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic        HREADYin;
  logic [31:0] HRDATA;
  logic        HREADYout;
  logic [1:0]  HRESP;
  logic [31:0] PRDATA;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic [3:0]  PSELx;

  modport slave (
    input  HADDR, HWDATA, HWRITE, HTRANS, HREADYin, PRDATA,
    output HRDATA, HREADYout, HRESP, PADDR, PWDATA, PWRITE, PENABLE, PSELx
  );

  modport master (
    output HADDR, HWDATA, HWRITE, HTRANS, HREADYin, PRDATA,
    input  HRDATA, HREADYout, HRESP, PADDR, PWDATA, PWRITE, PENABLE, PSELx
  );
endinterface

// File: rtl/modport_bridge.sv
// AHB-Lite to APB v2 bridge: one SETUP/ENABLE access per accepted transfer in 0x8xxx_xxxx.
// Latency: read data phase 2 cycles, write 3 cycles; HREADYout low in WWAIT and SETUP.
module modport_bridge (
  input logic             clock,
  input logic             reset,
  modport_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ENABLE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic        write_q, write_nxt;
  logic [3:0]  sel_q, sel_nxt;
  logic [3:0]  psel_q, psel_nxt;
  logic        penable_q, penable_nxt;
  logic        hready_q, hready_nxt;
  logic [31:0] paddr_q, paddr_nxt;
  logic [31:0] pwdata_q, pwdata_nxt;
  logic        pwrite_q, pwrite_nxt;
  logic        valid;
  logic [3:0]  dec;

  assign valid = bus.HREADYin && bus.HTRANS[1] && (bus.HADDR[31:28] == 4'h8);
  assign dec   = 4'b0001 << bus.HADDR[27:26];

  // All APB outputs are registered from the next state, so they are glitch-free Moore outputs.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    write_nxt   = write_q;
    sel_nxt     = sel_q;
    psel_nxt    = 4'b0000;
    penable_nxt = 1'b0;
    hready_nxt  = 1'b1;
    paddr_nxt   = paddr_q;
    pwdata_nxt  = pwdata_q;
    pwrite_nxt  = pwrite_q;
    case (state)
      ST_IDLE, ST_ENABLE: begin
        if (valid) begin
          addr_nxt   = bus.HADDR;
          write_nxt  = bus.HWRITE;
          sel_nxt    = dec;
          hready_nxt = 1'b0;
          if (bus.HWRITE) begin
            state_nxt = ST_WWAIT;
          end else begin
            state_nxt  = ST_SETUP;
            psel_nxt   = dec;
            paddr_nxt  = bus.HADDR;
            pwrite_nxt = 1'b0;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WWAIT: begin
        state_nxt  = ST_SETUP;
        hready_nxt = 1'b0;
        pwdata_nxt = bus.HWDATA;
        psel_nxt   = sel_q;
        paddr_nxt  = addr_q;
        pwrite_nxt = write_q;
      end
      ST_SETUP: begin
        state_nxt   = ST_ENABLE;
        psel_nxt    = psel_q;
        penable_nxt = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_q    <= 32'h0;
      write_q   <= 1'b0;
      sel_q     <= 4'b0000;
      psel_q    <= 4'b0000;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      pwrite_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      write_q   <= write_nxt;
      sel_q     <= sel_nxt;
      psel_q    <= psel_nxt;
      penable_q <= penable_nxt;
      hready_q  <= hready_nxt;
      paddr_q   <= paddr_nxt;
      pwdata_q  <= pwdata_nxt;
      pwrite_q  <= pwrite_nxt;
    end
  end

  assign bus.PSELx     = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.HREADYout = hready_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.HRDATA    = bus.PRDATA;
  assign bus.HRESP     = 2'b00;

endmodule

// File: tb/tb_modport_bridge.sv
// Bench for modport_bridge: a transaction-trace model predicts every cycle's outputs,
// and directed sequences pin key cycles to hand-computed literals.
module tb_modport_bridge;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  modport_bridge_if bus ();

  modport_bridge dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [3:0]  psel;
    logic        pen;
    logic        hrdy;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        wwait;
    logic        use_wdata;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  exp_t        prev;
  exp_t        nxt;
  logic [31:0] wdata_cap;

  function automatic exp_t mk(input logic [3:0] psel, input logic pen, input logic hrdy,
                              input logic [31:0] paddr, input logic pwrite,
                              input logic wwait, input logic use_wdata);
    exp_t r;
    r.psel      = psel;
    r.pen       = pen;
    r.hrdy      = hrdy;
    r.paddr     = paddr;
    r.pwrite    = pwrite;
    r.pwdata    = 32'h0;
    r.wwait     = wwait;
    r.use_wdata = use_wdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Trace model: an accepted transfer expands into the list of cycles it must produce.
  always @(posedge clock) begin
    logic [31:0] a;
    logic [3:0]  s;
    if (reset) begin
      q.delete();
      cur = mk(4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    end else begin
      prev = cur;
      if (cur.wwait) wdata_cap = bus.HWDATA;
      if (cur.hrdy && bus.HREADYin && bus.HTRANS[1] && bus.HADDR[31:28] == 4'h8) begin
        a = bus.HADDR;
        s = 4'b0001 << a[27:26];
        if (bus.HWRITE) begin
          q.push_back(mk(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
          q.push_back(mk(s, 1'b0, 1'b0, a, 1'b1, 1'b0, 1'b1));
          q.push_back(mk(s, 1'b1, 1'b1, a, 1'b1, 1'b0, 1'b1));
        end else begin
          q.push_back(mk(s, 1'b0, 1'b0, a, 1'b0, 1'b0, 1'b0));
          q.push_back(mk(s, 1'b1, 1'b1, a, 1'b0, 1'b0, 1'b0));
        end
      end
      if (q.size() != 0) nxt = q.pop_front();
      else nxt = mk(4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      if (nxt.psel == 4'b0000) begin
        nxt.paddr  = prev.paddr;
        nxt.pwrite = prev.pwrite;
        nxt.pwdata = prev.pwdata;
      end else if (nxt.use_wdata) begin
        nxt.pwdata = wdata_cap;
      end else begin
        nxt.pwdata = prev.pwdata;
      end
      cur = nxt;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset) e = mk(4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    else e = cur;
    chk("cyc_psel", {28'h0, bus.PSELx}, {28'h0, e.psel});
    chk("cyc_penable", {31'h0, bus.PENABLE}, {31'h0, e.pen});
    chk("cyc_hready", {31'h0, bus.HREADYout}, {31'h0, e.hrdy});
    chk("cyc_paddr", bus.PADDR, e.paddr);
    chk("cyc_pwrite", {31'h0, bus.PWRITE}, {31'h0, e.pwrite});
    chk("cyc_pwdata", bus.PWDATA, e.pwdata);
    chk("cyc_hresp", {30'h0, bus.HRESP}, 32'h0);
    chk("cyc_hrdata", bus.HRDATA, bus.PRDATA);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [1:0] t);
    bus.HADDR  = a;
    bus.HWRITE = w;
    bus.HTRANS = t;
  endtask

  task automatic no_xfer();
    bus.HTRANS = 2'b00;
  endtask

  initial begin
    logic [31:0] ign_addr[4];
    logic [1:0]  ign_trans[4];
    logic        ign_rdy[4];
    logic [31:0] a;
    checks      = 0;
    failures    = 0;
    wdata_cap   = 32'h0;
    cur         = mk(4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    reset       = 1'b1;
    bus.HADDR   = 32'h0;
    bus.HWDATA  = 32'h0;
    bus.HWRITE  = 1'b0;
    bus.HTRANS  = 2'b00;
    bus.HREADYin = 1'b1;
    bus.PRDATA  = 32'h0;

    repeat (2) step();
    chk("rst_psel", {28'h0, bus.PSELx}, 32'h0);
    chk("rst_hready", {31'h0, bus.HREADYout}, 32'h1);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    reset = 1'b0;
    step();

    // Single write
    addr_phase(32'h8400_0010, 1'b1, 2'b10);
    step();
    no_xfer();
    bus.HWDATA = 32'hDEAD_BEEF;
    chk("wr_wwait_hready", {31'h0, bus.HREADYout}, 32'h0);
    chk("wr_wwait_psel", {28'h0, bus.PSELx}, 32'h0);
    step();
    bus.HWDATA = 32'h0;
    chk("wr_setup_psel", {28'h0, bus.PSELx}, 32'h2);
    chk("wr_setup_pwrite", {31'h0, bus.PWRITE}, 32'h1);
    chk("wr_setup_paddr", bus.PADDR, 32'h8400_0010);
    chk("wr_setup_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    chk("wr_setup_hready", {31'h0, bus.HREADYout}, 32'h0);
    chk("model_wr_setup_pwdata", cur.pwdata, 32'hDEAD_BEEF);
    step();
    chk("wr_enable_penable", {31'h0, bus.PENABLE}, 32'h1);
    chk("wr_enable_hready", {31'h0, bus.HREADYout}, 32'h1);
    chk("wr_enable_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    step();
    chk("wr_after_psel", {28'h0, bus.PSELx}, 32'h0);
    chk("wr_after_paddr_hold", bus.PADDR, 32'h8400_0010);

    // Single read
    bus.PRDATA = 32'h1234_5678;
    addr_phase(32'h8C00_0004, 1'b0, 2'b10);
    step();
    no_xfer();
    chk("rd_setup_psel", {28'h0, bus.PSELx}, 32'h8);
    chk("rd_setup_pwrite", {31'h0, bus.PWRITE}, 32'h0);
    chk("rd_setup_hready", {31'h0, bus.HREADYout}, 32'h0);
    chk("model_rd_setup_psel", {28'h0, cur.psel}, 32'h8);
    step();
    chk("rd_enable_penable", {31'h0, bus.PENABLE}, 32'h1);
    chk("rd_enable_hready", {31'h0, bus.HREADYout}, 32'h1);
    chk("rd_enable_hrdata", bus.HRDATA, 32'h1234_5678);
    step();
    chk("rd_after_penable", {31'h0, bus.PENABLE}, 32'h0);

    // Ignored transfers: out of range, BUSY, IDLE, HREADYin low
    ign_addr  = '{32'h9000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    ign_trans = '{2'b10, 2'b01, 2'b00, 2'b10};
    ign_rdy   = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      addr_phase(ign_addr[i], 1'b0, ign_trans[i]);
      bus.HREADYin = ign_rdy[i];
      step();
      no_xfer();
      bus.HREADYin = 1'b1;
      chk($sformatf("ign%0d_psel", i), {28'h0, bus.PSELx}, 32'h0);
      chk($sformatf("ign%0d_hready", i), {31'h0, bus.HREADYout}, 32'h1);
      step();
      chk($sformatf("ign%0d_psel_late", i), {28'h0, bus.PSELx}, 32'h0);
    end

    // Back-to-back read then write, second address phase presented in ENABLE
    bus.PRDATA = 32'h0BAD_F00D;
    addr_phase(32'h8000_0000, 1'b0, 2'b10);
    step();
    no_xfer();
    chk("b2b_c1_psel", {28'h0, bus.PSELx}, 32'h1);
    step();
    chk("b2b_c2_psel", {28'h0, bus.PSELx}, 32'h1);
    addr_phase(32'h8800_0000, 1'b1, 2'b11);
    step();
    no_xfer();
    bus.HWDATA = 32'hCAFE_F00D;
    chk("b2b_c3_psel", {28'h0, bus.PSELx}, 32'h0);
    chk("b2b_c3_hready", {31'h0, bus.HREADYout}, 32'h0);
    step();
    chk("b2b_c4_psel", {28'h0, bus.PSELx}, 32'h4);
    chk("b2b_c4_pwdata", bus.PWDATA, 32'hCAFE_F00D);
    step();
    chk("b2b_c5_psel", {28'h0, bus.PSELx}, 32'h4);
    chk("b2b_c5_penable", {31'h0, bus.PENABLE}, 32'h1);
    step();

    // All four decode regions
    for (int i = 0; i < 4; i++) begin
      a = 32'h8000_0000 | (32'(i) << 26) | 32'(i * 4);
      bus.PRDATA = 32'hA5A5_0000 + 32'(i);
      addr_phase(a, 1'b0, 2'b10);
      step();
      no_xfer();
      chk($sformatf("dec%0d_psel", i), {28'h0, bus.PSELx}, 32'h1 << i);
      chk($sformatf("dec%0d_paddr", i), bus.PADDR, a);
      step();
      chk($sformatf("dec%0d_hrdata", i), bus.HRDATA, 32'hA5A5_0000 + 32'(i));
      chk($sformatf("dec%0d_hresp", i), {30'h0, bus.HRESP}, 32'h0);
      step();
    end

    // Reset asserted mid-write during SETUP
    addr_phase(32'h8000_0020, 1'b1, 2'b10);
    step();
    no_xfer();
    bus.HWDATA = 32'h1111_1111;
    step();
    chk("mrst_pre_psel", {28'h0, bus.PSELx}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("mrst_psel", {28'h0, bus.PSELx}, 32'h0);
    chk("mrst_penable", {31'h0, bus.PENABLE}, 32'h0);
    chk("mrst_hready", {31'h0, bus.HREADYout}, 32'h1);
    chk("mrst_pwdata", bus.PWDATA, 32'h0);
    step();
    step();
    reset = 1'b0;
    chk("mrst_after_penable", {31'h0, bus.PENABLE}, 32'h0);
    addr_phase(32'h8400_0000, 1'b0, 2'b10);
    step();
    no_xfer();
    chk("mrst_read_psel", {28'h0, bus.PSELx}, 32'h2);
    chk("mrst_read_hready", {31'h0, bus.HREADYout}, 32'h0);
    step();
    chk("mrst_read_penable", {31'h0, bus.PENABLE}, 32'h1);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modport_bridge.md
# modport_bridge

AHB-Lite slave to APB (v2, no PREADY) master bridge. It accepts single AHB transfers targeting 0x8000_0000–0x8FFF_FFFF and converts each into one APB SETUP/ENABLE access to one of four peripherals selected by one-hot PSELx. It sits between the AHB bus fabric and the APB peripheral bus.

## Interface
- Parameters: none.
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- HADDR  in  32  AHB address
- HWDATA  in  32  AHB write data, valid in data phase
- HWRITE  in  1  1 = write, 0 = read
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HREADYin  in  1  bus ready; address phase is sampled only when high
- HRDATA  out  32  read data to AHB
- HREADYout  out  1  transfer-complete / bridge ready
- HRESP  out  2  response; constant 2'b00 (OKAY)
- PRDATA  in  32  APB read data
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB enable phase
- PSELx  out  4  one-hot APB slave select

## Operation
- Valid transfer: HREADYin=1, HTRANS ∈ {NONSEQ, SEQ}, HADDR[31:28]=4'h8. Sampled at rising edge in IDLE or ENABLE state only.
- Decode: HADDR[27:26] = 0/1/2/3 → PSELx = 0001/0010/0100/1000.
- Non-valid inputs (IDLE/BUSY, HREADYin=0, out-of-range address) are ignored: no APB access, HREADYout stays 1, HRESP OKAY.
- On acceptance, latch HADDR, HWRITE, and the decoded select.
- FSM states: IDLE, WWAIT, SETUP, ENABLE.
  - IDLE: valid write → WWAIT; valid read → SETUP; else IDLE.
  - WWAIT: latch HWDATA into PWDATA → SETUP.
  - SETUP → ENABLE unconditionally.
  - ENABLE: valid write → WWAIT; valid read → SETUP; else IDLE.
- Outputs are registered (Moore):
  - SETUP: PSELx = latched one-hot, PENABLE=0, PADDR = latched address, PWRITE = latched direction.
  - ENABLE: same values with PENABLE=1.
  - IDLE/WWAIT: PSELx=0, PENABLE=0; PADDR, PWRITE and PWDATA hold their last values.
- HREADYout: 0 in WWAIT and SETUP; 1 in IDLE and ENABLE.
- HRDATA = PRDATA, combinational pass-through. The AHB master samples it when HREADYout=1 in ENABLE of a read.
- HRESP is tied to 2'b00.

## Timing
- Reset values: state IDLE, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HREADYout=1, HRESP=0.
- Asserting reset mid-transfer aborts the transfer immediately (asynchronous) and forces all reset values; no partial APB access completes.
- Read (address phase in cycle T0):
  - T1 SETUP, HREADYout=0.
  - T2 ENABLE, PENABLE=1, HREADYout=1; HRDATA = PRDATA in T2.
  - AHB data phase lasts 2 cycles.
- Write (address phase in T0, HWDATA valid in T1):
  - T1 WWAIT, HREADYout=0, HWDATA captured at end of T1.
  - T2 SETUP with PWDATA valid.
  - T3 ENABLE, HREADYout=1.
  - AHB data phase lasts 3 cycles.
- PSELx is asserted for exactly 2 cycles per access; PENABLE only in the second.
- Back-to-back: a valid address phase in an ENABLE cycle is accepted. The next SETUP or WWAIT follows with no IDLE cycle between; PSELx may stay high across consecutive accesses.
- PADDR, PWRITE, PSELx and PWDATA are stable from SETUP through ENABLE.

## Test plan
- Reset with reset=1 mid-write (during SETUP) → next sample shows PSELx=0, PENABLE=0, HREADYout=1, state IDLE.
- Single write to 0x8400_0010, HWDATA=0xDEADBEEF:
  - PSELx=0010, PWRITE=1, PADDR=0x8400_0010, PWDATA=0xDEADBEEF in SETUP and ENABLE.
  - HREADYout low 2 cycles.
- Single read from 0x8C00_0004 with PRDATA=0x1234_5678:
  - PSELx=1000, PWRITE=0, PENABLE high 1 cycle.
  - HRDATA=0x1234_5678 when HREADYout=1; HREADYout low 1 cycle.
- Out-of-range NONSEQ read at 0x9000_0000 and IDLE/BUSY at 0x8000_0000 → PSELx stays 0, HREADYout stays 1.
- Back-to-back read 0x8000_0000 then write 0x8800_0000 (second address presented in ENABLE):
  - PSELx 0001,0001,0000(WWAIT),0100,0100.
  - No IDLE cycle between the two accesses.
- All four decode regions, HADDR[27:26]=0..3 → PSELx 0001/0010/0100/1000; HRESP=00 throughout.
